// File: rtl/block_read_unit_pkg.sv
// Shared definitions for the block read unit and the address-register users.
// Holds the 2-bit FSM state encoding, default bus widths and a helper that
// sizes the memory-latency counter.
package block_read_unit_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_LEN_W  = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   // Bits needed to hold the value lat (lat >= 1).
   function automatic int lat_cnt_w(input int lat);
      return (lat < 2) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/block_read_unit_latency_counter.sv
// Loadable down-counter with a last-count flag, for fixed-latency memory
// interfaces.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   load_i      load load_val_i (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one (saturates at zero)
//   last_o      counter currently holds 1, i.e. this is the final cycle
module block_read_unit_latency_counter #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             last_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/block_read_unit.sv
// Block read unit: walks a contiguous region of data memory, one read at a
// time, and streams each word out over a valid/ready port.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   start, abort          begin (IDLE only) / cancel a transfer
//   start_addr, length    first address and word count, sampled with start
//   busy, done            not-IDLE flag; one-cycle completion pulse
//   mem_rd_en, mem_addr   read strobe and address toward data memory
//   mem_rdata             read data, valid MEM_LAT edges after the strobe
//   out_data, out_valid   captured word toward the consumer
//   out_ready             consumer accept
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | mem_rd_en high for one cycle, latency counter loaded
// WAIT  | counting down memory latency, capture data on the last count
// HOLD  | word presented, waiting for out_ready
module block_read_unit
   import block_read_unit_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int CNT_W = lat_cnt_w(MEM_LAT);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              cnt_load, cnt_dec, cnt_last;

   block_read_unit_latency_counter #(
      .CNT_W (CNT_W)
   ) u_lat_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load),
      .load_val_i (CNT_W'(MEM_LAT)),
      .dec_i      (cnt_dec),
      .last_o     (cnt_last)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      data_d   = data_q;
      valid_d  = valid_q;
      done_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  addr_d  = start_addr;
                  rem_d   = length;
                  state_d = ST_ISSUE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            cnt_load = 1'b1;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_dec = 1'b1;
            if (cnt_last) begin
               data_d  = mem_rdata;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               valid_d = 1'b0;
               addr_d  = addr_q + ADDR_W'(1);
               rem_d   = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides everything, including a final handshake in HOLD;
      // the address stays where it was and any in-flight read is dropped.
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         addr_d  = addr_q;
         rem_d   = rem_q;
         valid_d = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign mem_rd_en = (state_q == ST_ISSUE);
   assign mem_addr  = addr_q;
   assign out_data  = data_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_block_read_unit.sv
module tb_block_read_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] start_addr;
   logic [15:0] length;
   logic        busy;
   logic        done;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:65535];
   logic [15:0] rd_log [$];
   int          done_cnt = 0;
   int          overlap_cnt = 0;

   logic [15:0] words [0:7];
   int          stamp [0:7];
   int          nw;

   block_read_unit #(
      .ADDR_W  (16),
      .DATA_W  (16),
      .LEN_W   (16),
      .MEM_LAT (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .start_addr (start_addr),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory, one-edge latency; garbage when not reading.
   always @(posedge clk) begin
      mem_rdata <= mem_rd_en ? mem[mem_addr] : 16'hDEAD;
   end

   always @(negedge clk) begin
      if (rst_n && mem_rd_en) rd_log.push_back(mem_addr);
      if (rst_n && done) done_cnt++;
      if (done && out_valid) overlap_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Call right after the tick on which start was sampled (cycle 1 = ISSUE).
   // Stalls word stall_idx for stall_len cycles, checking it stays put.
   task automatic collect(input int n, input int stall_idx, input int stall_len);
      int cyc;
      int left;
      logic [15:0] held;
      cyc  = 1;
      nw   = 0;
      left = stall_len;
      held = '0;
      for (int i = 0; i < 8; i++) begin
         words[i] = 16'h0;
         stamp[i] = -1;
      end
      while (nw < n && cyc < 200) begin
         if (out_valid) begin
            if (nw == stall_idx && left > 0) begin
               if (left == stall_len) held = out_data;
               else check("stall_data", {16'h0, out_data}, {16'h0, held});
               out_ready = 1'b0;
               left--;
            end else begin
               out_ready = 1'b1;
               words[nw] = out_data;
               stamp[nw] = cyc;
               nw++;
            end
         end
         tick();
         cyc++;
      end
      out_ready = 1'b1;
      check("word_count", nw, n);
   endtask

   task automatic do_start(input logic [15:0] a, input logic [15:0] len);
      start_addr = a;
      length     = len;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic check_end(input string tag, input logic [15:0] end_addr, input int done_base);
      check({tag, "_done"}, {31'h0, done}, 32'h1);
      check({tag, "_busy"}, {31'h0, busy}, 32'h0);
      check({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
      check({tag, "_addr"}, {16'h0, mem_addr}, {16'h0, end_addr});
      tick();
      check({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
      check({tag, "_done_cnt"}, done_cnt - done_base, 1);
   endtask

   initial begin
      int rb;
      int db;

      for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
      mem[16'h0010] = 16'h00A0; mem[16'h0011] = 16'h00A1;
      mem[16'h0012] = 16'h00A2; mem[16'h0013] = 16'h00A3;
      mem[16'h0020] = 16'h00B0; mem[16'h0021] = 16'h00B1;
      mem[16'h0022] = 16'h00B2; mem[16'h0023] = 16'h00B3;
      mem[16'hFFFE] = 16'h00C0; mem[16'hFFFF] = 16'h00C1;
      mem[16'h0000] = 16'h00C2;
      mem[16'h0100] = 16'h00D0;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      start_addr = '0; length = '0; out_ready = 1'b1;
      tick();
      tick();
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
      check("rst_addr", {16'h0, mem_addr}, 32'h0);
      check("rst_data", {16'h0, out_data}, 32'h0);
      check("rst_valid", {31'h0, out_valid}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Basic read
      rb = rd_log.size(); db = done_cnt;
      do_start(16'h0010, 16'd4);
      check("basic_rd_en_first", {31'h0, mem_rd_en}, 32'h1);
      check("basic_addr_first", {16'h0, mem_addr}, 32'h0010);
      collect(4, -1, 0);
      for (int i = 0; i < 4; i++) begin
         check("basic_word", {16'h0, words[i]}, 32'h00A0 + 32'(i));
         check("basic_stamp", stamp[i], 3 * i + 3);
      end
      check_end("basic", 16'h0014, db);
      check("basic_rd_cnt", rd_log.size() - rb, 4);
      for (int i = 0; i < 4; i++)
         check("basic_rd_addr", {16'h0, rd_log[rb + i]}, 32'h0010 + 32'(i));

      // Backpressure on word 2 for five cycles
      rb = rd_log.size(); db = done_cnt;
      do_start(16'h0020, 16'd4);
      collect(4, 1, 5);
      for (int i = 0; i < 4; i++)
         check("bp_word", {16'h0, words[i]}, 32'h00B0 + 32'(i));
      check("bp_stamp1", stamp[1], 11);
      check("bp_stamp3", stamp[3], 17);
      check_end("bp", 16'h0024, db);
      check("bp_rd_cnt", rd_log.size() - rb, 4);

      // Wrap-around
      rb = rd_log.size(); db = done_cnt;
      do_start(16'hFFFE, 16'd3);
      collect(3, -1, 0);
      for (int i = 0; i < 3; i++)
         check("wrap_word", {16'h0, words[i]}, 32'h00C0 + 32'(i));
      check_end("wrap", 16'h0001, db);
      check("wrap_rd0", {16'h0, rd_log[rb]}, 32'hFFFE);
      check("wrap_rd1", {16'h0, rd_log[rb + 1]}, 32'hFFFF);
      check("wrap_rd2", {16'h0, rd_log[rb + 2]}, 32'h0000);

      // Zero length
      rb = rd_log.size(); db = done_cnt;
      do_start(16'h0050, 16'd0);
      check("zero_done", {31'h0, done}, 32'h1);
      check("zero_busy", {31'h0, busy}, 32'h0);
      check("zero_rd_en", {31'h0, mem_rd_en}, 32'h0);
      tick();
      check("zero_done_pulse", {31'h0, done}, 32'h0);
      check("zero_busy2", {31'h0, busy}, 32'h0);
      check("zero_rd_cnt", rd_log.size() - rb, 0);
      check("zero_done_cnt", done_cnt - db, 1);

      // Abort during WAIT of word 2, then restart
      db = done_cnt;
      do_start(16'h0010, 16'd4);
      tick(); tick(); tick(); tick();
      check("abort_pre_busy", {31'h0, busy}, 32'h1);
      check("abort_pre_addr", {16'h0, mem_addr}, 32'h0011);
      check("abort_pre_valid", {31'h0, out_valid}, 32'h0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_valid", {31'h0, out_valid}, 32'h0);
      check("abort_done", {31'h0, done}, 32'h0);
      check("abort_addr", {16'h0, mem_addr}, 32'h0011);
      tick(); tick();
      check("abort_valid_late", {31'h0, out_valid}, 32'h0);
      check("abort_done_cnt", done_cnt - db, 0);
      rb = rd_log.size();
      do_start(16'h0100, 16'd1);
      collect(1, -1, 0);
      check("restart_word", {16'h0, words[0]}, 32'h00D0);
      check_end("restart", 16'h0101, db);
      check("restart_rd", {16'h0, rd_log[rb]}, 32'h0100);

      // Abort coincident with the final handshake
      db = done_cnt;
      do_start(16'h0100, 16'd1);
      tick(); tick();
      check("abhs_valid", {31'h0, out_valid}, 32'h1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abhs_done", {31'h0, done}, 32'h0);
      check("abhs_busy", {31'h0, busy}, 32'h0);
      check("abhs_addr", {16'h0, mem_addr}, 32'h0100);
      tick();
      check("abhs_done_cnt", done_cnt - db, 0);

      // Async reset in HOLD
      out_ready = 1'b0;
      do_start(16'h0010, 16'd4);
      tick(); tick();
      check("ar_pre_valid", {31'h0, out_valid}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_busy", {31'h0, busy}, 32'h0);
      check("ar_valid", {31'h0, out_valid}, 32'h0);
      check("ar_data", {16'h0, out_data}, 32'h0);
      check("ar_addr", {16'h0, mem_addr}, 32'h0);
      check("ar_rd_en", {31'h0, mem_rd_en}, 32'h0);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      tick();

      // Restart after reset; start held high while busy must be ignored
      rb = rd_log.size(); db = done_cnt;
      do_start(16'h0020, 16'd2);
      start_addr = 16'h0100;
      length     = 16'd1;
      start      = 1'b1;
      collect(2, -1, 0);
      start = 1'b0;
      check("ign_word0", {16'h0, words[0]}, 32'h00B0);
      check("ign_word1", {16'h0, words[1]}, 32'h00B1);
      check("ign_stamp1", stamp[1], 6);
      check_end("ign", 16'h0022, db);
      check("ign_rd_cnt", rd_log.size() - rb, 2);

      check("done_valid_overlap", overlap_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
